// File: rtl/prga_fifo_pkg.sv
// Shared definitions for the PRGA FIFO family: pointer sizing, threshold
// legality and the two output modes.
package prga_fifo_pkg;

    // Output modes
    localparam int LOOKAHEAD_REG  = 0;  // dout registered, loads on accepted read
    localparam int LOOKAHEAD_FWFT = 1;  // head entry shown combinationally

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    // Watermark thresholds must lie in 0..DEPTH-1
    function automatic bit thres_legal(input int thres, input int depth_log2);
        return (thres >= 0) && (thres < (1 << depth_log2));
    endfunction

endpackage

// File: rtl/prga_fifo_ext_ram.sv
// DEPTH x DATA_WIDTH flop storage: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module prga_fifo_ext_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prga_fifo_ext.sv
// Parametrised synchronous FIFO with registered or lookahead output,
// occupancy count and almost-full/almost-empty watermarks.
// Optional sticky overflow/underflow flags: define PRGA_FIFO_ERROR_EN.
module prga_fifo_ext
    import prga_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_LOG2   = 3,
    parameter int LOOKAHEAD    = 0,
    parameter int AFULL_THRES  = 1,
    parameter int AEMPTY_THRES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = ptr_width(DEPTH_LOG2);

    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_THRES);
    localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_THRES);

    if (!thres_legal(AFULL_THRES, DEPTH_LOG2) || !thres_legal(AEMPTY_THRES, DEPTH_LOG2)) begin : g_bad_thres
        $error("prga_fifo_ext: watermark threshold outside 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr, rd_ptr, occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_acc, rd_acc;

    // Flags come only from registered pointers, so no wr/rd-to-output path
    always_comb begin
        occ          = wr_ptr - rd_ptr;
        empty        = (occ == '0);
        full         = (occ == DEPTH_P);
        almost_full  = ((DEPTH_P - occ) <= AFULL_P);
        almost_empty = (occ <= AEMPTY_P);
        wr_acc       = wr && !full;
        rd_acc       = rd && !empty;
    end

    assign count = occ;

    // Pointer advance on accepted operations only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    prga_fifo_ext_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (din),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (head)
    );

    if (LOOKAHEAD == LOOKAHEAD_REG) begin : g_reg_out
        logic [DATA_WIDTH-1:0] dout_q;
        // Capture the head entry as it is popped; hold on rejected reads
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         dout_q <= '0;
            else if (rd_acc) dout_q <= head;
        end
        assign dout = dout_q;
    end else begin : g_fwft_out
        assign dout = head;
    end

`ifdef PRGA_FIFO_ERROR_EN
    // Sticky error flags: set on any rejected request, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && full)  overflow  <= 1'b1;
            if (rd && empty) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_prga_fifo_ext.sv
// Bench for prga_fifo_ext: a registered-output and a lookahead instance share
// one stimulus stream and are compared each cycle against a queue model.
module tb_prga_fifo_ext;

    localparam int DW    = 8;
    localparam int DL2   = 3;
    localparam int DEPTH = 8;
    localparam int AF0 = 1, AE0 = 1;
    localparam int AF1 = 2, AE1 = 3;
`ifdef PRGA_FIFO_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr = 1'b0, rd = 1'b0;
    logic [DW-1:0] din = '0;

    logic full0, af0, empty0, ae0, ovf0, udf0;
    logic full1, af1, empty1, ae1, ovf1, udf1;
    logic [DL2:0] count0, count1;
    logic [DW-1:0] dout0, dout1;

    int checks = 0;
    int failures = 0;

    logic [7:0] vals [8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};

    always #5 clk = ~clk;

    prga_fifo_ext #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(0),
                    .AFULL_THRES(AF0), .AEMPTY_THRES(AE0)) u_dut0 (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full0), .almost_full(af0),
        .rd(rd), .dout(dout0), .empty(empty0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0));

    prga_fifo_ext #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(1),
                    .AFULL_THRES(AF1), .AEMPTY_THRES(AE1)) u_dut1 (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full1), .almost_full(af1),
        .rd(rd), .dout(dout1), .empty(empty1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1));

    // Reference model: contents as a queue, registered dout, sticky errors
    logic [7:0] q [$];
    logic [7:0] m_dout0 = '0;
    bit m_ovf = 0, m_udf = 0;
    bit m_wa, m_ra;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_dout0 = '0;
            m_ovf = 0;
            m_udf = 0;
        end else begin
            m_wa = wr && (q.size() < DEPTH);
            m_ra = rd && (q.size() > 0);
            if (wr && !m_wa) m_ovf = 1;
            if (rd && !m_ra) m_udf = 1;
            if (m_ra) m_dout0 = q.pop_front();
            if (m_wa) q.push_back(din);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        int n = q.size();
        check("count0",  count0, n);
        check("empty0",  empty0, n == 0);
        check("full0",   full0,  n == DEPTH);
        check("afull0",  af0,    (DEPTH - n) <= AF0);
        check("aempty0", ae0,    n <= AE0);
        check("count1",  count1, n);
        check("empty1",  empty1, n == 0);
        check("full1",   full1,  n == DEPTH);
        check("afull1",  af1,    (DEPTH - n) <= AF1);
        check("aempty1", ae1,    n <= AE1);
        check("dout0",   dout0,  m_dout0);
        if (n > 0) check("dout1", dout1, q[0]);
        check("ovf0", ovf0, ERR_EN & m_ovf);
        check("udf0", udf0, ERR_EN & m_udf);
        check("ovf1", ovf1, ERR_EN & m_ovf);
        check("udf1", udf1, ERR_EN & m_udf);
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) cmp_all();

    task automatic cyc(input bit w, input bit r, input logic [7:0] d);
        @(negedge clk);
        wr = w; rd = r; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count0, 0);
        check("rst_empty", empty0, 1);
        check("rst_aempty", ae0, 1);
        check("rst_full", full0, 0);
        check("rst_afull", af0, 0);
        check("rst_dout", dout0, 8'h00);
        check("rst_ovf", ovf0, 0);
        check("rst_udf", udf0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with no reads, then one dropped write
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, vals[i]);
            check("fill_count", count0, i + 1);
            check("fill_afull", af0, (i + 1) >= 7);
            check("fill_full", full0, i == 7);
            check("fill_head1", dout1, 8'h5A);
        end
        cyc(1, 0, 8'h11);
        check("ovf_count", count0, 8);
        check("ovf_flag", ovf0, ERR_EN);

        // Registered-output drain in order, then a rejected read
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 8'h00);
            check("drain_dout", dout0, vals[i]);
            check("drain_count", count0, 7 - i);
        end
        check("drain_empty", empty0, 1);
        cyc(0, 1, 8'h00);
        check("udf_hold", dout0, 8'h7A);
        check("udf_flag", udf0, ERR_EN);

        // Lookahead visibility
        cyc(1, 0, 8'h5A);
        check("la_empty", empty1, 0);
        check("la_head", dout1, 8'h5A);
        cyc(1, 0, 8'hF6);
        cyc(0, 1, 8'h00);
        check("la_pop", dout1, 8'hF6);
        check("la_reg", dout0, 8'h5A);
        cyc(0, 1, 8'h00);
        check("la_empty2", empty1, 1);
        check("la_reg2", dout0, 8'hF6);

        // Simultaneous rd+wr at count 4
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h10 + 8'(i));
        cyc(1, 1, 8'h14);
        check("rw4_count", count0, 4);
        check("rw4_dout", dout0, 8'h10);
        // Simultaneous rd+wr at full: write dropped
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h15 + 8'(i));
        cyc(1, 1, 8'h99);
        check("rwf_count", count0, 7);
        check("rwf_dout", dout0, 8'h11);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 8'h00);
            check("rwf_drain", dout0, 8'h12 + i);
        end
        // Simultaneous rd+wr at empty: read dropped
        cyc(1, 1, 8'h3C);
        check("rwe_count", count0, 1);
        cyc(0, 1, 8'h00);
        check("rwe_dout", dout0, 8'h3C);

        // Interleaved stream across pointer wraps
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 8'(i));
            if (i > 0) check("wrap_dout", dout0, i - 1);
            check("wrap_count", count0, 1);
        end
        cyc(0, 1, 8'h00);
        check("wrap_last", dout0, 8'h13);

        // Randomised phases biased toward full, toward empty, and balanced
        for (int p = 0; p < 6; p++) begin
            pw = (p % 3 == 0) ? 75 : ((p % 3 == 1) ? 25 : 50);
            for (int c = 0; c < 300; c++)
                cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 8'($urandom));
        end

        // Reset mid-cycle with data stored
        repeat (10) cyc(0, 1, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h40 + 8'(i));
        cyc(0, 0, 8'h00);
        check("prerst_count", count0, 5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_count0", count0, 0);
        check("mrst_empty0", empty0, 1);
        check("mrst_aempty0", ae0, 1);
        check("mrst_count1", count1, 0);
        check("mrst_dout0", dout0, 8'h00);
        check("mrst_ovf", ovf0, 0);
        check("mrst_udf", udf0, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 8'hAB);
        check("post_rst_head", dout1, 8'hAB);
        check("post_rst_count", count1, 1);
        cyc(0, 0, 8'h00);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prga_fifo_ext.md
# prga_fifo_ext

Parametrised synchronous FIFO: next generation of the PRGA FIFO, generalised in depth, with selectable lookahead (first-word-fall-through) or registered-read output, occupancy count, programmable almost-full/almost-empty flags, and optional sticky error flags. Sits between PRGA programming/bitstream datapaths and their producers/consumers wherever depth or watermarking beyond the fixed FIFO is needed.

## Interface
- DATA_WIDTH, 8, payload width
- DEPTH_LOG2, 3, log2 of entry count; DEPTH = 2^DEPTH_LOG2
- LOOKAHEAD, 0, 1 = head entry visible on dout while !empty; 0 = dout updates one cycle after an accepted read
- AFULL_THRES, 1, almost_full when free slots <= AFULL_THRES; legal range 0..DEPTH-1
- AEMPTY_THRES, 1, almost_empty when count <= AEMPTY_THRES; legal range 0..DEPTH-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr  in  1  write request
- din  in  DATA_WIDTH  write data
- full  out  1  no free slot
- almost_full  out  1  watermark flag
- rd  in  1  read request (LOOKAHEAD=1: pop/acknowledge)
- dout  out  DATA_WIDTH  read data
- empty  out  1  no stored entry
- almost_empty  out  1  watermark flag
- count  out  DEPTH_LOG2+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Read/write pointers are DEPTH_LOG2+1 bits (wrap bit); count = wr_ptr - rd_ptr modulo 2^(DEPTH_LOG2+1); empty = (count==0), full = (count==DEPTH); flags derived combinationally from registered pointers.
- Write accepted iff wr && !full; read accepted iff rd && !empty. Rejected requests have no effect on pointers, storage or dout.
- Simultaneous rd+wr: each evaluated against pre-edge flags. At full: read accepted, write dropped (count DEPTH->DEPTH-1). At empty: write accepted, read dropped (count 0->1). Otherwise count unchanged.
- LOOKAHEAD=0: dout is a register loaded with the head entry on accepted read; holds otherwise.
- LOOKAHEAD=1: dout = storage[rd_ptr] combinationally; valid only while !empty; value undefined when empty.
- Storage array is not reset; pointers, count, flags and dout register are.
- Reset values: full 0, almost_full 0, empty 1, almost_empty 1, count 0, dout 0 (LOOKAHEAD=0), overflow 0, underflow 0. Reset takes effect immediately on assertion, including mid-stream; all stored data discarded.

## Timing
- Write-to-empty deassert: 1 edge (write at edge N, empty=0 and count updated in cycle after N).
- LOOKAHEAD=0 read latency: rd accepted at edge N, data on dout after edge N.
- LOOKAHEAD=1: head data visible in same cycle empty=0; accepted pop at edge N exposes next entry after edge N.
- Full/almost flags update on the edge following the accepted operation; no combinational path from wr/rd to any output.

## Configuration
- PRGA_FIFO_ERROR_EN defined: overflow set on any edge with wr && full; underflow set on any edge with rd && empty; both sticky until rst.
- Undefined: overflow and underflow tied to 0, no error logic synthesised; ports remain for interface stability.

## Structure
- Shared package prga_fifo_pkg: pointer-width function (DEPTH_LOG2+1), threshold legality checks, common localparams for LOOKAHEAD modes.
- One sub-module: prga_fifo_ext_ram, DEPTH x DATA_WIDTH flop array, one write port, one asynchronous read port; pointer/flag/output logic stays in prga_fifo_ext.

## Test plan
- Reset with DEPTH_LOG2=3: count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0x00, overflow=underflow=0.
- Write 0x5A,0xF6,0x09,0xC4,0x81,0xE2,0xA0,0x7A with no reads -> almost_full at count 7, full at count 8; 9th write 0x11 dropped, overflow=1 (with PRGA_FIFO_ERROR_EN), count stays 8.
- LOOKAHEAD=0 drain of above: dout 0x5A after first accepted rd, ... 0x7A after eighth; empty=1; ninth rd -> dout holds 0x7A, underflow=1.
- LOOKAHEAD=1: write 0x5A at edge N -> cycle after N empty=0, dout=0x5A; write 0xF6, pop -> dout=0xF6; pop -> empty=1.
- Simultaneous rd+wr: at count 4 -> count 4 and order preserved; at full -> count 7, write data absent from drain; at empty -> count 1, dout later shows written value.
- Wrap and reset: 20 interleaved writes/reads (values 0x00..0x13) -> read order identical, pointers wrap twice; assert rst at count 5 mid-cycle -> empty=1, count=0, sticky flags cleared immediately.
